// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch time base with run/pause, sync clear and a blinking adjust mode.
// Digit value 4'd10 marks a blanked digit for the downstream 7-segment multiplexer.
module stopwatch_counter #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz_i,
    input  logic       tick_2hz_i,
    input  logic       tick_blink_i,
    input  logic       pause_pulse_i,
    input  logic       clear_pulse_i,
    input  logic       adj_i,
    input  logic       sel_i,
    output logic [3:0] minutes_tens_o,
    output logic [3:0] minutes_ones_o,
    output logic [3:0] seconds_tens_o,
    output logic [3:0] seconds_ones_o,
    output logic       running_o
);

    localparam logic [1:0] StRun    = 2'd0;
    localparam logic [1:0] StPaused = 2'd1;
    localparam logic [1:0] StAdjust = 2'd2;

    localparam logic [3:0] MaxMinTens = 4'(MAX_MIN / 10);
    localparam logic [3:0] MaxMinOnes = 4'(MAX_MIN % 10);
    localparam logic [3:0] Blank      = 4'd10;

    logic [1:0] state_q, state_d;
    logic       paused_q, paused_d;
    logic       blink_q, blink_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic       sec_wrap;
    logic       blank_sel;

    function automatic logic [7:0] sec_inc(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd9) begin
            if (tens == 4'd5) return 8'h00;
            return {tens + 4'd1, 4'd0};
        end
        return {tens, ones + 4'd1};
    endfunction

    // Minutes wrap on the full two-digit value so any MAX_MIN in 1..99 works.
    function automatic logic [7:0] min_inc(input logic [3:0] tens, input logic [3:0] ones);
        if (tens == MaxMinTens && ones == MaxMinOnes) return 8'h00;
        if (ones == 4'd9) return {tens + 4'd1, 4'd0};
        return {tens, ones + 4'd1};
    endfunction

    assign sec_wrap = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);

    always_comb begin
        state_d  = state_q;
        paused_d = paused_q;
        if (adj_i) begin
            state_d = StAdjust;
        end else begin
            case (state_q)
                StAdjust: state_d = paused_q ? StPaused : StRun;
                StRun:    state_d = pause_pulse_i ? StPaused : StRun;
                StPaused: state_d = pause_pulse_i ? StRun : StPaused;
                default:  state_d = StRun;
            endcase
        end
        if (state_q != StAdjust && pause_pulse_i) begin
            paused_d = ~paused_q;
        end
    end

    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        if (clear_pulse_i) begin
            min_tens_d = 4'd0;
            min_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            sec_ones_d = 4'd0;
        end else if (state_q == StRun && tick_1hz_i) begin
            {sec_tens_d, sec_ones_d} = sec_inc(sec_tens_q, sec_ones_q);
            if (sec_wrap) begin
                {min_tens_d, min_ones_d} = min_inc(min_tens_q, min_ones_q);
            end
        end else if (state_q == StAdjust && tick_2hz_i) begin
            if (sel_i) begin
                {sec_tens_d, sec_ones_d} = sec_inc(sec_tens_q, sec_ones_q);
            end else begin
                {min_tens_d, min_ones_d} = min_inc(min_tens_q, min_ones_q);
            end
        end
    end

    // Blink phase follows the next state so it is never left set outside adjust mode.
    always_comb begin
        blink_d = 1'b0;
        if (state_d == StAdjust) begin
            blink_d = tick_blink_i ? ~blink_q : blink_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            paused_q   <= 1'b0;
            blink_q    <= 1'b0;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            paused_q   <= paused_d;
            blink_q    <= blink_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
        end
    end

    assign blank_sel = (state_q == StAdjust) && blink_q;

    always_comb begin
        minutes_tens_o = (blank_sel && !sel_i) ? Blank : min_tens_q;
        minutes_ones_o = (blank_sel && !sel_i) ? Blank : min_ones_q;
        seconds_tens_o = (blank_sel && sel_i) ? Blank : sec_tens_q;
        seconds_ones_o = (blank_sel && sel_i) ? Blank : sec_ones_q;
        running_o      = (state_q == StRun);
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Random and directed checks of stopwatch_counter against an integer mm:ss reference model.
module tb_stopwatch_counter;

    localparam int unsigned MaxMin = 59;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       t1, t2, tb, pp, cp, adj, sel;
    logic [3:0] mt, mo, st, so;
    logic       running;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain integers, mode 0 = run, 1 = paused, 2 = adjust.
    int m_min, m_sec, m_mode, m_pf, m_blink;

    stopwatch_counter #(.MAX_MIN(MaxMin)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick_1hz_i     (t1),
        .tick_2hz_i     (t2),
        .tick_blink_i   (tb),
        .pause_pulse_i  (pp),
        .clear_pulse_i  (cp),
        .adj_i          (adj),
        .sel_i          (sel),
        .minutes_tens_o (mt),
        .minutes_ones_o (mo),
        .seconds_tens_o (st),
        .seconds_ones_o (so),
        .running_o      (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int a, input int b, input int c, input int d,
                                       input int r);
        return {15'd0, 4'(a), 4'(b), 4'(c), 4'(d), 1'(r)};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {15'd0, mt, mo, st, so, running};
    endfunction

    function automatic logic [31:0] model_vec();
        int  a, b, c, d;
        bit  blank;
        blank = (m_mode == 2) && (m_blink != 0);
        a = (blank && !sel) ? 10 : m_min / 10;
        b = (blank && !sel) ? 10 : m_min % 10;
        c = (blank && sel) ? 10 : m_sec / 10;
        d = (blank && sel) ? 10 : m_sec % 10;
        return mk(a, b, c, d, (m_mode == 0) ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_mode = 0; m_pf = 0; m_blink = 0;
    endtask

    task automatic model_step();
        int old_mode;
        old_mode = m_mode;
        if (adj) m_mode = 2;
        else if (old_mode == 2) m_mode = m_pf;
        else if (pp) m_mode = 1 - old_mode;
        if (old_mode != 2 && pp) m_pf = 1 - m_pf;
        if (cp) begin
            m_min = 0; m_sec = 0;
        end else if (old_mode == 0 && t1) begin
            m_sec = m_sec + 1;
            if (m_sec == 60) begin
                m_sec = 0;
                m_min = (m_min == int'(MaxMin)) ? 0 : m_min + 1;
            end
        end else if (old_mode == 2 && t2) begin
            if (sel) m_sec = (m_sec + 1) % 60;
            else m_min = (m_min == int'(MaxMin)) ? 0 : m_min + 1;
        end
        m_blink = (m_mode == 2) ? (m_blink ^ int'(tb)) : 0;
    endtask

    // One clock: drive on the falling edge, update model on the rising edge, compare just after.
    task automatic step(input logic i_t1, input logic i_t2, input logic i_tb, input logic i_pp,
                        input logic i_cp, input logic i_adj, input logic i_sel);
        @(negedge clk);
        t1 = i_t1; t2 = i_t2; tb = i_tb; pp = i_pp; cp = i_cp; adj = i_adj; sel = i_sel;
        @(posedge clk);
        model_step();
        #1;
        check("cycle", dut_vec(), model_vec());
    endtask

    task automatic async_reset();
        #2;
        t1 = 0; t2 = 0; tb = 0; pp = 0; cp = 0; adj = 0; sel = 0;
        rst_n = 1'b0;
        #1;
        check("async_rst", dut_vec(), mk(0, 0, 0, 0, 1));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        t1 = 0; t2 = 0; tb = 0; pp = 0; cp = 0; adj = 0; sel = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check("reset", dut_vec(), mk(0, 0, 0, 0, 1));
        @(negedge clk);
        rst_n = 1'b1;

        // 61 seconds -> 01:01
        for (int i = 0; i < 61; i++) step(1, 0, 0, 0, 0, 0, 0);
        check("t1_0101", dut_vec(), mk(0, 1, 0, 1, 1));

        // Preset 59:59 in adjust, then one second wraps to 00:00
        step(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0, 1, 1);
        check("adj_5959", dut_vec(), mk(5, 9, 5, 9, 0));
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("wrap_0000", dut_vec(), mk(0, 0, 0, 0, 1));

        // Pause holds, resume continues
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0);
        check("paused_hold", dut_vec(), mk(0, 0, 0, 5, 0));
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
        check("resume_0008", dut_vec(), mk(0, 0, 0, 8, 1));

        // Adjust seconds from 00:58 wraps without minute carry, then blink blanks seconds
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 58; i++) step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, 1);
        check("adj_no_carry", dut_vec(), mk(0, 0, 0, 1, 0));
        step(0, 0, 1, 0, 0, 1, 1);
        check("blink_sec", dut_vec(), mk(0, 0, 10, 10, 0));
        async_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_run", {31'd0, running}, 32'd1);

        // Clear beats tick; clear with pause still pauses
        for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        check("clear_tick", dut_vec(), mk(0, 0, 0, 0, 1));
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0);
        check("clear_pause", dut_vec(), mk(0, 0, 0, 0, 0));
        step(0, 0, 0, 1, 0, 0, 0);

        // Randomized run against the model
        begin
            logic r_adj, r_sel;
            r_adj = 0; r_sel = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(15) == 0) r_adj = ~r_adj;
                if ($urandom_range(7) == 0) r_sel = ~r_sel;
                step(1'($urandom_range(2) == 0), 1'($urandom_range(2) == 0),
                     1'($urandom_range(3) == 0), 1'($urandom_range(11) == 0),
                     1'($urandom_range(59) == 0), r_adj, r_sel);
                if ($urandom_range(499) == 0) begin
                    async_reset();
                    r_adj = 0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
